// File: rtl/and_not_pkg.sv
// Shared types and constants for the and-not gate self-test sweep.
// Holds the FSM state encoding, the fixed vector order and the golden gate function.
package and_not_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int NUM_VEC = 4;

  // Sweep order of {a,b}; golden outputs are 0, 1, 0, 0.
  localparam logic [1:0] VEC [0:NUM_VEC-1] = '{2'b00, 2'b10, 2'b11, 2'b01};

  function automatic logic golden(input logic a, input logic b);
    return a & ~b;
  endfunction

endpackage

// File: rtl/and_not_cell.sv
// Gate under test: z = a & ~b.
// Instantiated next to the sweep controller by a bench or BIST top.
module and_not_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_z
);

  logic w_b_n;

  assign w_b_n = ~i_b;
  assign o_z   = i_a & w_b_n;

endmodule

// File: rtl/and_not_sweep_ctrl.sv
// Clocked self-test sweep for one and-not gate: drive each vector, wait,
// sample z_i, compare with golden, and keep pass/fail counts plus first failure.
module and_not_sweep_ctrl
  import and_not_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             z_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [1:0]       first_fail_vec
);

  localparam int               SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES);
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           r_state;
  state_e           w_next;
  logic [1:0]       r_idx;
  logic [SC_W-1:0]  r_settle_cnt;
  logic             r_a;
  logic             r_b;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_fail_seen;
  logic [1:0]       r_first_fail;
  logic             w_match;

  assign w_match = (z_i == golden(r_a, r_b));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DRIVE;
      DRIVE:   w_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (r_settle_cnt == SC_W'(1)) w_next = SAMPLE;
      SAMPLE:  w_next = (r_idx == LAST_IDX) ? DONE : DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx        <= '0;
            {r_a, r_b}   <= VEC[0];
            r_pass       <= '0;
            r_fail       <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= 2'b00;
          end
        end
        DRIVE:  r_settle_cnt <= SETTLE_LOAD;
        SETTLE: r_settle_cnt <= r_settle_cnt - SC_W'(1);
        SAMPLE: begin
          if (w_match) begin
            r_pass <= r_pass + CNT_ONE;
          end else begin
            r_fail <= r_fail + CNT_ONE;
            if (!r_fail_seen) begin
              r_fail_seen  <= 1'b1;
              r_first_fail <= {r_a, r_b};
            end
          end
          // The last vector stays on the gate inputs after the sweep.
          if (r_idx != LAST_IDX) begin
            r_idx      <= r_idx + 2'd1;
            {r_a, r_b} <= VEC[r_idx + 2'd1];
          end
        end
        default: ;
      endcase
    end
  end

  assign a_o            = r_a;
  assign b_o            = r_b;
  assign busy           = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
  assign done           = (r_state == DONE);
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign fail_seen      = r_fail_seen;
  assign first_fail_vec = r_first_fail;

endmodule

// File: tb/tb_and_not_sweep_ctrl.sv
// Scoreboard bench: two controllers (settle 2 and settle 0) sweep a selectable
// gate model; expected sweep results are queued at start and checked on done.
module tb_and_not_sweep_ctrl;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start2, start0;
  logic a2, b2, busy2, done2, seen2, z2, zc2;
  logic a0, b0, busy0, done0, seen0, z0, zc0;
  logic [CNT_W-1:0] pass2, fail2, pass0, fail0;
  logic [1:0] ffv2, ffv0;

  int mode;   // 0 and-not cell, 1 plain AND, 2 tied 0, 3 tied 1
  bit sel0;   // 1: the settle-0 controller is under test

  int n_err = 0;
  int n_checks = 0;

  typedef struct {
    int pass_n;
    int fail_n;
    int seen;
    int ffv;
    int busy_len;
    int seq;
  } exp_t;

  exp_t exp_q[$];

  and_not_cell u_cell2 (.i_a(a2), .i_b(b2), .o_z(zc2));
  and_not_cell u_cell0 (.i_a(a0), .i_b(b0), .o_z(zc0));

  function automatic logic alt_z(int m, logic a, logic b);
    case (m)
      1:       return a & b;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    z2 = (mode == 0) ? zc2 : alt_z(mode, a2, b2);
    z0 = (mode == 0) ? zc0 : alt_z(mode, a0, b0);
  end

  and_not_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .z_i(z2),
    .a_o(a2), .b_o(b2), .busy(busy2), .done(done2),
    .pass_cnt(pass2), .fail_cnt(fail2), .fail_seen(seen2), .first_fail_vec(ffv2)
  );

  and_not_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .z_i(z0),
    .a_o(a0), .b_o(b0), .busy(busy0), .done(done0),
    .pass_cnt(pass0), .fail_cnt(fail0), .fail_seen(seen0), .first_fail_vec(ffv0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the gate's truth table per mode versus the golden and-not.
  function automatic int ref_z(int m, int a, int b);
    case (m)
      0:       return (a == 1 && b == 0) ? 1 : 0;
      1:       return (a == 1 && b == 1) ? 1 : 0;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t model(int m, int settle);
    exp_t e;
    int order [4];
    int a, b, want;
    order = '{2, 3, 1, 0};
    order = '{0, 2, 3, 1};
    e = '{default: 0};
    for (int i = 0; i < 4; i++) begin
      a    = order[i] / 2;
      b    = order[i] % 2;
      want = (a == 1 && b == 0) ? 1 : 0;
      if (ref_z(m, a, b) == want) e.pass_n++;
      else begin
        e.fail_n++;
        if (e.seen == 0) begin
          e.seen = 1;
          e.ffv  = order[i];
        end
      end
      e.seq = e.seq * 4 + order[i];
    end
    e.busy_len = 4 * (2 + settle);
    return e;
  endfunction

  // Monitor: tracks the busy window and vector sequence, checks on each done.
  int         busy_len = 0;
  int         n_seg = 0;
  logic [7:0] seq_rec = '0;
  logic [1:0] last_ab = '0;
  exp_t       mon_e;

  initial begin
    logic m_busy, m_done, m_seen;
    logic [1:0] m_ab, m_ffv;
    logic [CNT_W-1:0] m_pass, m_fail;
    forever begin
      @(negedge clk);
      m_busy = sel0 ? busy0 : busy2;
      m_done = sel0 ? done0 : done2;
      m_ab   = sel0 ? {a0, b0} : {a2, b2};
      m_pass = sel0 ? pass0 : pass2;
      m_fail = sel0 ? fail0 : fail2;
      m_seen = sel0 ? seen0 : seen2;
      m_ffv  = sel0 ? ffv0 : ffv2;
      if (rst) begin
        busy_len = 0;
        n_seg    = 0;
        seq_rec  = '0;
        continue;
      end
      if (m_busy) begin
        if (busy_len == 0 || m_ab != last_ab) begin
          seq_rec = {seq_rec[5:0], m_ab};
          n_seg++;
        end
        last_ab = m_ab;
        busy_len++;
      end
      if (m_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pass_cnt", m_pass, mon_e.pass_n);
          check("fail_cnt", m_fail, mon_e.fail_n);
          check("fail_seen", m_seen, mon_e.seen);
          if (mon_e.seen != 0) check("first_fail_vec", m_ffv, mon_e.ffv);
          check("busy_len", busy_len, mon_e.busy_len);
          check("vec_seq", seq_rec, mon_e.seq);
          check("vec_segments", n_seg, 4);
          check("busy_at_done", m_busy, 0);
          check("count_sum", 32'(m_pass) + 32'(m_fail), 4);
          check("last_vec_held", m_ab, 2'b01);
        end
        busy_len = 0;
        n_seg    = 0;
        seq_rec  = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_busy();
    return sel0 ? busy0 : busy2;
  endfunction

  function automatic logic cur_done();
    return sel0 ? done0 : done2;
  endfunction

  task automatic set_start(input logic v);
    if (sel0) start0 = v;
    else      start2 = v;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((cur_busy() || cur_done()) && k < 200) begin
      tick();
      k++;
    end
    check(name, (cur_busy() || cur_done()) ? 0 : 1, 1);
  endtask

  task automatic check_reset_all();
    check("rst_a2", a2, 0);       check("rst_b2", b2, 0);
    check("rst_busy2", busy2, 0); check("rst_done2", done2, 0);
    check("rst_pass2", pass2, 0); check("rst_fail2", fail2, 0);
    check("rst_seen2", seen2, 0); check("rst_ffv2", ffv2, 0);
    check("rst_a0", a0, 0);       check("rst_b0", b0, 0);
    check("rst_busy0", busy0, 0); check("rst_done0", done0, 0);
    check("rst_pass0", pass0, 0); check("rst_fail0", fail0, 0);
    check("rst_seen0", seen0, 0); check("rst_ffv0", ffv0, 0);
  endtask

  // One sweep; with noisy set, random start pulses land inside busy and DONE.
  task automatic run_sweep(input int m, input bit noisy);
    int settle, len;
    wait_idle("idle_before_start");
    mode   = m;
    settle = sel0 ? 0 : 2;
    len    = 4 * (2 + settle);
    exp_q.push_back(model(m, settle));
    set_start(1'b1);
    tick();
    for (int i = 1; i <= len; i++) begin
      set_start(noisy ? ($urandom_range(0, 2) == 0) : 1'b0);
      tick();
    end
    set_start(1'b0);
    wait_idle("sweep_finished");
  endtask

  initial begin
    int k;
    rst    = 1'b1;
    start2 = 1'b0;
    start0 = 1'b0;
    mode   = 0;
    sel0   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      check_reset_all();
    end

    // Directed sweeps on the settle-2 controller.
    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);

    // Reset during SETTLE of vector 2.
    wait_idle("idle_before_rst_sweep");
    mode = 0;
    exp_q.push_back(model(0, 2));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while ({a2, b2} != 2'b11 && k < 50) begin
      tick();
      k++;
    end
    check("reach_vec2", {a2, b2}, 2'b11);
    tick();
    rst = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    tick();
    check_reset_all();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("no_done_after_rst", done2, 0);
    end
    run_sweep(0, 1'b1);

    // Settle-0 controller: plain sweep, then start held high.
    sel0 = 1'b1;
    run_sweep(0, 1'b0);
    wait_idle("idle_before_held");
    mode = 0;
    repeat (3) exp_q.push_back(model(0, 0));
    start0 = 1'b1;
    k = 0;
    while (!busy0 && k < 10) begin
      tick();
      k++;
    end
    check("held_first_busy", busy0, 1);
    repeat (2) begin
      k = 0;
      while (!done0 && k < 50) begin
        tick();
        k++;
      end
      check("held_done", done0, 1);
      k = 0;
      do begin
        tick();
        k++;
      end while (!busy0 && k < 10);
      check("held_gap", k, 2);
    end
    start0 = 1'b0;
    wait_idle("idle_after_held");

    // Randomized sweeps across both controllers and all gate models.
    for (int i = 0; i < 12; i++) begin
      sel0 = ($urandom_range(0, 1) == 1);
      run_sweep(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/and_not_sweep_ctrl.md
Name: and_not_sweep_ctrl

Overview:
Self-test sequencer for the 2-input and-not gate cell (z = a & ~b). On a start pulse it drives the four input vectors in the fixed order (a,b) = 00, 10, 11, 01. After each vector it waits a programmable settle time, samples the gate output and compares it against the golden value. It then reports pass/fail counts and the first failing vector. It sits between a bench or BIST top and one gate instance, and replaces hand-written #10 stimulus with a clocked sweep.

Parameters:
SETTLE_CYCLES, 2, cycles waited between driving a vector and sampling z_i; 0 is legal and skips SETTLE.
CNT_W, 3, width of pass/fail counters; must be >= 3 so the count 4 fits.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  sweep request; sampled only in IDLE.
z_i  input  1  output of the gate under test.
a_o  output  1  gate input a, registered.
b_o  output  1  gate input b, registered.
busy  output  1  high from DRIVE through the last SAMPLE.
done  output  1  one-cycle pulse when the sweep completes.
pass_cnt  output  CNT_W  vectors that matched, for the current or last sweep.
fail_cnt  output  CNT_W  vectors that mismatched.
fail_seen  output  1  sticky; set on the first mismatch of a sweep.
first_fail_vec  output  2  {a,b} of the first mismatching vector; valid when fail_seen=1.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, a_o=0, b_o=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, fail_seen=0, first_fail_vec=2'b00, vector index=0, settle counter=0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: clear pass_cnt, fail_cnt, fail_seen and first_fail_vec. Set idx=0 and load a_o/b_o from the vector table. Go to DRIVE.
- Vector table (idx -> {a,b}): 0 -> 00, 1 -> 10, 2 -> 11, 3 -> 01. Golden value exp = a_o & ~b_o, i.e. 0, 1, 0, 0.
- DRIVE: lasts 1 cycle. Go to SETTLE and load the settle counter with SETTLE_CYCLES. If SETTLE_CYCLES=0, go directly to SAMPLE.
- SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle the counter reaches 1.
- SAMPLE: lasts 1 cycle. Compare z_i with exp.
  - Equal: pass_cnt += 1.
  - Not equal: fail_cnt += 1. If fail_seen=0, set fail_seen=1 and first_fail_vec={a_o,b_o}.
  - If idx=3, go to DONE. Otherwise idx += 1, load the next vector into a_o/b_o, and go to DRIVE.
- DONE: done=1 for exactly 1 cycle, busy=0. Next state is IDLE.
- Holds across the sweep:
  - Counters and fail flags hold their values until the next accepted start.
  - a_o/b_o hold the last vector (01) after the sweep.
- Timing:
  - Per-vector latency is 2 + SETTLE_CYCLES cycles.
  - busy is high for 4*(2+SETTLE_CYCLES) cycles; 16 at the default.
  - done asserts the cycle after the final SAMPLE.
- Boundary conditions:
  - start while busy or in DONE: ignored, no restart.
  - start held high continuously: a new sweep begins from the IDLE cycle following DONE.
  - rst mid-sweep: immediate return to the reset values above on the next edge; no done pulse.
  - Counters cannot overflow, since the maximum is 4 with CNT_W >= 3.
  - pass_cnt + fail_cnt = 4 at done, always.
  - z_i is sampled only in SAMPLE; glitches in other states have no effect.

Decomposition:
- Shared package and_not_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - the localparam vector table VEC[0:3] = {2'b00, 2'b10, 2'b11, 2'b01};
  - NUM_VEC = 4;
  - a function golden(a,b) = a & ~b.
- One sub-module is natural: and_not_cell, the gate under test (NOT of b, AND with a). The bench instantiates it next to the controller. The controller itself stays a single module: FSM plus settle counter plus counters.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, busy=0, no done.
- Correct and_not_cell wired to a_o/b_o/z_i, start pulse, SETTLE_CYCLES=2 -> busy high 16 cycles; a_o/b_o sequence 00, 10, 11, 01; done pulse; pass_cnt=4, fail_cnt=0, fail_seen=0.
- Plain AND gate substituted (z = a & b) -> mismatches on 10 and 11; pass_cnt=2, fail_cnt=2, fail_seen=1, first_fail_vec=2'b10.
- z_i tied to 0 -> only vector 10 fails; pass_cnt=3, fail_cnt=1, first_fail_vec=2'b10.
- rst asserted during SETTLE of vector 2, then start again -> reset values on the edge after rst, no done pulse. The new sweep gives pass_cnt=4 and a full 16-cycle busy window. Start pulses mid-sweep are ignored (sweep length unchanged).
- SETTLE_CYCLES=0 build, correct gate -> busy high 8 cycles, pass_cnt=4. Start held high -> back-to-back sweeps separated by DONE+IDLE (2 cycles).
